// File: rtl/conv_window_former.sv
// Sliding KERNEL_SIZE x KERNEL_SIZE window former (stride 1, no padding) fed one
// vertically aligned pixel column per transfer, with a single output register stage.
module conv_window_former #(
    parameter int KERNEL_SIZE = 3,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                                      clk,
    input  logic                                      reset_n,
    input  logic                                      col_valid,
    output logic                                      col_ready,
    input  logic [KERNEL_SIZE*DATA_WIDTH-1:0]         col_data,
    input  logic                                      col_eol,
    input  logic                                      col_sof,
    output logic                                      win_valid,
    input  logic                                      win_ready,
    output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] win_data,
    output logic [13:0]                               win_col,
    output logic [13:0]                               win_row,
    output logic                                      win_last,
    output logic                                      err_short
);

    localparam int          CW    = KERNEL_SIZE * DATA_WIDTH;
    localparam int          WW    = KERNEL_SIZE * KERNEL_SIZE * DATA_WIDTH;
    localparam logic [13:0] PRIME = 14'(KERNEL_SIZE - 1);

    logic [CW-1:0] shift_q [KERNEL_SIZE];
    logic [CW-1:0] shift_d [KERNEL_SIZE];
    logic [WW-1:0] win_next;
    logic [13:0]   col_cnt;
    logic [13:0]   row_cnt;
    logic [13:0]   eff_cnt;
    logic [13:0]   cnt_inc;
    logic [13:0]   base_row;
    logic          accept;
    logic          forms;

    assign col_ready = ~win_valid | win_ready;
    assign accept    = col_valid & col_ready;

    // A start-of-frame column restarts priming and row numbering on this very transfer.
    assign eff_cnt  = col_sof ? '0 : col_cnt;
    assign base_row = col_sof ? '0 : row_cnt;
    assign forms    = (eff_cnt >= PRIME);
    assign cnt_inc  = (eff_cnt == '1) ? eff_cnt : eff_cnt + 14'd1;

    always_comb begin
        for (int unsigned c = 0; c < KERNEL_SIZE - 1; c++) begin
            shift_d[c] = shift_q[c+1];
        end
        shift_d[KERNEL_SIZE-1] = col_data;
    end

    always_comb begin
        win_next = '0;
        for (int unsigned r = 0; r < KERNEL_SIZE; r++) begin
            for (int unsigned c = 0; c < KERNEL_SIZE; c++) begin
                win_next[(r*KERNEL_SIZE+c)*DATA_WIDTH +: DATA_WIDTH] = shift_d[c][r*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned c = 0; c < KERNEL_SIZE; c++) begin
                shift_q[c] <= '0;
            end
            col_cnt   <= '0;
            row_cnt   <= '0;
            win_valid <= 1'b0;
            win_data  <= '0;
            win_col   <= '0;
            win_row   <= '0;
            win_last  <= 1'b0;
            err_short <= 1'b0;
        end else if (accept) begin
            shift_q <= shift_d;
            col_cnt <= col_eol ? '0 : cnt_inc;
            row_cnt <= base_row;
            if (forms) begin
                win_valid <= 1'b1;
                win_data  <= win_next;
                win_col   <= eff_cnt - PRIME;
                win_row   <= base_row;
                win_last  <= col_eol;
                if (col_eol) begin
                    row_cnt <= base_row + 14'd1;
                end
            end else begin
                win_valid <= 1'b0;
                if (col_eol) begin
                    err_short <= 1'b1;
                end
            end
        end else if (win_ready) begin
            win_valid <= 1'b0;
        end
    end

endmodule
